// File: rtl/vdp_arb_pkg.sv
// Shared types for the VDP register-port arbiter: grant encoding, lock states
// and the write record carried through the CPU buffer.
package vdp_arb_pkg;

  localparam int VDP_ADDR_W = 6;
  localparam int VDP_DATA_W = 16;

  typedef enum logic {
    GRANT_CPU    = 1'b0,
    GRANT_COPPER = 1'b1
  } grant_t;

  typedef enum logic {
    LOCK_IDLE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_t;

  typedef struct packed {
    logic [VDP_ADDR_W-1:0] address;
    logic [VDP_DATA_W-1:0] data;
  } wr_rec_t;

  function automatic grant_t other_grant(input grant_t g);
    return (g == GRANT_CPU) ? GRANT_COPPER : GRANT_CPU;
  endfunction

endpackage

// File: rtl/vdp_arb_fifo.sv
// Synchronous FIFO for buffered CPU writes; full/empty are registered from the
// next-state occupancy so they carry no combinational path from push/pop.
module vdp_arb_fifo
  import vdp_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = VDP_ADDR_W + VDP_DATA_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             do_push;
  logic             do_pop;

  // A push while full is refused even if a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + 1'b1;
    end else if (do_pop && !do_push) begin
      count_next = count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == FULL_CNT);
      empty <= (count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/vdp_register_arbiter.sv
// Arbitrates the single VDP register write port between buffered CPU writes and
// the copper handshake, with round-robin fairness and a copper burst lock.
module vdp_register_arbiter
  import vdp_arb_pkg::*;
#(
  parameter int CPU_FIFO_DEPTH = 2,
  parameter int ADDR_WIDTH     = VDP_ADDR_W,
  parameter int DATA_WIDTH     = VDP_DATA_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_write_en,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  input  logic [DATA_WIDTH-1:0] cpu_data,
  output logic                  cpu_busy,
  input  logic                  copper_valid,
  input  logic [ADDR_WIDTH-1:0] copper_address,
  input  logic [DATA_WIDTH-1:0] copper_data,
  input  logic                  copper_lock,
  output logic                  copper_ready,
  output logic                  overflow,
  input  logic                  overflow_clear,
  output logic                  write_en_out,
  output logic [ADDR_WIDTH-1:0] address_out,
  output logic [DATA_WIDTH-1:0] data_out
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data;
  } rec_t;

  localparam int REC_W = ADDR_WIDTH + DATA_WIDTH;

  rec_t        cpu_rec_in;
  rec_t        cpu_head;
  rec_t        cop_rec;
  rec_t        grant_rec_p0;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_pop;
  logic        req_cpu;
  logic        req_cop;
  logic        grant_vld_p0;
  grant_t      grant_sel_p0;
  grant_t      last_grant;
  lock_state_t lock_state;
  lock_state_t lock_state_next;
  logic        lock_active;
  logic        cop_xfer;

  assign cpu_rec_in = '{address: cpu_address, data: cpu_data};
  assign cop_rec    = '{address: copper_address, data: copper_data};

  vdp_arb_fifo #(
    .DEPTH (CPU_FIFO_DEPTH),
    .WIDTH (REC_W)
  ) u_cpu_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (cpu_write_en),
    .pop     (fifo_pop),
    .wr_data (cpu_rec_in),
    .rd_data (cpu_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign cpu_busy    = fifo_full;
  assign req_cpu     = !fifo_empty;
  assign req_cop     = copper_valid;
  assign lock_active = (lock_state == LOCK_HELD);

  // Stage p0: grant decision from current requests and arbiter state
  always_comb begin
    grant_vld_p0 = req_cpu || req_cop;
    grant_sel_p0 = GRANT_CPU;
    if (req_cpu && req_cop) begin
      if (copper_lock && lock_active) begin
        grant_sel_p0 = GRANT_COPPER;
      end else begin
        grant_sel_p0 = other_grant(last_grant);
      end
    end else if (req_cop) begin
      grant_sel_p0 = GRANT_COPPER;
    end
    grant_rec_p0 = (grant_sel_p0 == GRANT_COPPER) ? cop_rec : cpu_head;
  end

  assign copper_ready = !reset && req_cop && (grant_sel_p0 == GRANT_COPPER);
  assign cop_xfer     = copper_ready;
  assign fifo_pop     = req_cpu && (grant_sel_p0 == GRANT_CPU);

  // The lock only takes effect after the copper has won once with lock high,
  // so a locked burst cannot pre-empt a CPU write that was already due.
  always_comb begin
    lock_state_next = lock_state;
    case (lock_state)
      LOCK_IDLE: if (cop_xfer && copper_lock) lock_state_next = LOCK_HELD;
      LOCK_HELD: if (!copper_valid || !copper_lock) lock_state_next = LOCK_IDLE;
      default:   lock_state_next = LOCK_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_state <= LOCK_IDLE;
      last_grant <= GRANT_COPPER;
    end else begin
      lock_state <= lock_state_next;
      if (grant_vld_p0) last_grant <= grant_sel_p0;
    end
  end

  // Setting wins over a same-cycle clear so a drop is never hidden.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (cpu_write_en && fifo_full) begin
      overflow <= 1'b1;
    end else if (overflow_clear) begin
      overflow <= 1'b0;
    end
  end

  // Stage p1: registered write toward the register file
  always_ff @(posedge clk) begin
    if (reset) begin
      write_en_out <= 1'b0;
      address_out  <= '0;
      data_out     <= '0;
    end else begin
      write_en_out <= grant_vld_p0;
      if (grant_vld_p0) begin
        address_out <= grant_rec_p0.address;
        data_out    <= grant_rec_p0.data;
      end
    end
  end

endmodule

// File: doc/vdp_register_arbiter.md
Name: vdp_register_arbiter

Overview:
- Shares the single VDP register write port between two requesters: the CPU host path (1-cycle write strobes, no backpressure) and the copper/raster engine (valid/ready handshake).
- Buffers CPU writes in a small FIFO so none are lost while the copper owns the port.
- Round-robin arbitration, plus a copper lock for atomic mid-scanline bursts.
- Sits between the host interface / copper and the VDP register file; output is registered.

Parameters:
- CPU_FIFO_DEPTH, 2, CPU write buffer entries; power of two, 2..8.
- ADDR_WIDTH, 6, VDP register address width.
- DATA_WIDTH, 16, register data width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cpu_write_en  in  1  one-cycle CPU write strobe.
- cpu_address  in  ADDR_WIDTH  CPU register address; valid with the strobe.
- cpu_data  in  DATA_WIDTH  CPU write data; valid with the strobe.
- cpu_busy  out  1  FIFO full; host interface withholds ready while high.
- copper_valid  in  1  copper write request.
- copper_address  in  ADDR_WIDTH  copper register address.
- copper_data  in  DATA_WIDTH  copper write data.
- copper_lock  in  1  copper holds the port while high and valid.
- copper_ready  out  1  combinational grant; a transfer occurs when valid && ready.
- overflow  out  1  sticky: a CPU strobe was dropped.
- overflow_clear  in  1  clears overflow.
- write_en_out  out  1  register file write strobe.
- address_out  out  ADDR_WIDTH  register file address.
- data_out  out  DATA_WIDTH  register file data.

Behaviour:
- Reset values: write_en_out=0, address_out=0, data_out=0, overflow=0, cpu_busy=0, FIFO empty, last_grant=COPPER (so the CPU wins the first tie). Reset mid-burst discards all FIFO contents and pending grants.
- CPU FIFO:
  - Push on cpu_write_en when not full.
  - Push while full (including full with a same-cycle pop, which is treated as full): strobe dropped, overflow<=1.
  - Pop on a CPU grant.
  - Simultaneous push/pop when not full: count unchanged.
  - cpu_busy = (count == CPU_FIFO_DEPTH), registered from the next-state count.
  - Pointers wrap modulo depth.
- Latency: a CPU strobe into an empty FIFO with no copper contention gives write_en_out in cycle N+2. Cycle N pushes, N+1 grants and pops, N+2 output is registered.
- Arbitration, evaluated each cycle; req_cpu = FIFO non-empty, req_cop = copper_valid:
  - Neither: no grant, write_en_out<=0, address/data hold.
  - One requester: that requester is granted.
  - Both, with copper_lock && lock_active: copper is granted. lock_active sets on the first copper grant with lock=1 and clears when lock drops or valid drops.
  - Both, otherwise: the requester not equal to last_grant is granted (strict alternation).
  - Grant updates last_grant.
  - Grant: write_en_out<=1, address_out/data_out<=granted entry, the next cycle.
- copper_ready = !reset && req_cop && (grant==COPPER), combinational from current state.
- Lock starvation bound: none enforced. cpu_busy back-pressures the host, so no writes are lost unless the host ignores busy.
- overflow: set has priority over overflow_clear in the same cycle.
- Ordering: CPU writes emerge in strobe order. Copper writes emerge in handshake order. No ordering is guaranteed between the two streams.

Decomposition:
- Package vdp_arb_pkg: grant encoding (GRANT_CPU=0, GRANT_COPPER=1) and a write-record struct {address, data}.
- One sub-module, vdp_arb_fifo: synchronous FIFO with full/empty/count, parameterised on depth and record width.
- The arbiter FSM (last_grant, lock_active) and output register stay in the top module.

Test Plan:
- Single CPU write: cpu_write_en at cycle 0 with addr=0x05, data=0xBEEF, no copper. Expect write_en_out=1 at cycle 2, address_out=0x05, data_out=0xBEEF, for exactly one cycle.
- Contention alternation: copper_valid held (addr 0x10..0x13) while CPU strobes 0x01, 0x02. Expect output sequence CPU 0x01, COP 0x10, CPU 0x02, COP 0x11, COP 0x12, COP 0x13.
- Lock burst: copper_lock=1 for 4 writes (0x20..0x23) while CPU strobes 0x07. Expect all 4 copper writes back-to-back, then CPU 0x07. cpu_busy stays 0 (depth 2).
- Overflow: copper locked, CPU strobes 3 times (0x01, 0x02, 0x03) at depth 2. Expect cpu_busy=1 after the 2nd strobe, overflow=1 after the 3rd, and only 0x01 and 0x02 emitted after unlock. overflow_clear then drops overflow to 0.
- Reset mid-operation: FIFO holding 2 entries, reset asserted 1 cycle. Expect no further write_en_out, all outputs 0, cpu_busy=0, and the first post-reset tie granted to the CPU.
